// File: rtl/mod100_pkg.sv
// Shared constants for the mod-100 down counter display: segment codes,
// blank/off values and digit-select encoding.
package mod100_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [7:0] AN_OFF    = 8'hFF;
  localparam logic [7:0] AN_ONES   = 8'hFE;
  localparam logic [7:0] AN_TENS   = 8'hFD;

  // Active-low, bit order gfedcba
  localparam logic [6:0] SEG_0 = 7'b1000000;
  localparam logic [6:0] SEG_1 = 7'b1111001;
  localparam logic [6:0] SEG_2 = 7'b0100100;
  localparam logic [6:0] SEG_3 = 7'b0110000;
  localparam logic [6:0] SEG_4 = 7'b0011001;
  localparam logic [6:0] SEG_5 = 7'b0010010;
  localparam logic [6:0] SEG_6 = 7'b0000010;
  localparam logic [6:0] SEG_7 = 7'b1111000;
  localparam logic [6:0] SEG_8 = 7'b0000000;
  localparam logic [6:0] SEG_9 = 7'b0010000;

  typedef enum logic {
    DIG_ONES = 1'b0,
    DIG_TENS = 1'b1
  } dig_sel_e;

  typedef struct packed {
    logic [3:0] tens;
    logic [3:0] ones;
  } bcd2_t;

  localparam bcd2_t BCD_99 = '{tens: 4'd9, ones: 4'd9};

endpackage

// File: rtl/seg7_decode.sv
// BCD digit to active-low gfedcba segment pattern; non-BCD input blanks.
module seg7_decode
  import mod100_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (bcd)
      4'd0: seg = SEG_0;
      4'd1: seg = SEG_1;
      4'd2: seg = SEG_2;
      4'd3: seg = SEG_3;
      4'd4: seg = SEG_4;
      4'd5: seg = SEG_5;
      4'd6: seg = SEG_6;
      4'd7: seg = SEG_7;
      4'd8: seg = SEG_8;
      4'd9: seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/mod100_down_display.sv
// BCD 99..00 down counter ticked by a synchronised slow clock, driving a
// two-digit multiplexed 7-segment display. MOD100_DISPLAY_BLANK_EN blanks a leading zero.
module mod100_down_display
  import mod100_pkg::*;
#(
  parameter int SCAN_DIV = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sclk_in,
  input  logic       en,
  input  logic       load,
  output logic [3:0] tens,
  output logic [3:0] ones,
  output logic       wrap,
  output logic [6:0] seg,
  output logic       dp,
  output logic [7:0] an
);

  localparam int            SW        = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);

  logic          sync1_q, sync2_q, edge_q;
  logic          tick;
  bcd2_t         count_q, count_d;
  logic          wrap_q, wrap_d;
  logic [SW-1:0] scan_q, scan_d;
  dig_sel_e      sel_q, sel_d;
  logic [6:0]    seg_q, seg_d;
  logic [7:0]    an_q, an_d;
  logic [3:0]    digit;
  logic [6:0]    digit_seg;

  // Rising edge of the synchronised slow clock, one clk wide
  assign tick = sync2_q & ~edge_q;

  always_comb begin
    count_d = count_q;
    wrap_d  = 1'b0;
    if (load) begin
      count_d = BCD_99;
    end else if (tick && en) begin
      if (count_q.tens == 4'd0 && count_q.ones == 4'd0) begin
        count_d = BCD_99;
        wrap_d  = 1'b1;
      end else if (count_q.ones == 4'd0) begin
        count_d.ones = 4'd9;
        count_d.tens = count_q.tens - 4'd1;
      end else begin
        count_d.ones = count_q.ones - 4'd1;
      end
    end
  end

  always_comb begin
    scan_d = scan_q + SW'(1);
    sel_d  = sel_q;
    if (scan_q == SCAN_LAST) begin
      scan_d = '0;
      sel_d  = (sel_q == DIG_ONES) ? DIG_TENS : DIG_ONES;
    end
  end

  assign digit = (sel_q == DIG_TENS) ? count_q.tens : count_q.ones;

  seg7_decode u_dec (
    .bcd (digit),
    .seg (digit_seg)
  );

  always_comb begin
    seg_d = digit_seg;
    an_d  = (sel_q == DIG_TENS) ? AN_TENS : AN_ONES;
`ifdef MOD100_DISPLAY_BLANK_EN
    if (sel_q == DIG_TENS && count_q.tens == 4'd0) an_d = AN_OFF;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      edge_q  <= 1'b0;
      count_q <= BCD_99;
      wrap_q  <= 1'b0;
      scan_q  <= '0;
      sel_q   <= DIG_ONES;
      seg_q   <= SEG_BLANK;
      an_q    <= AN_OFF;
    end else begin
      sync1_q <= sclk_in;
      sync2_q <= sync1_q;
      edge_q  <= sync2_q;
      count_q <= count_d;
      wrap_q  <= wrap_d;
      scan_q  <= scan_d;
      sel_q   <= sel_d;
      seg_q   <= seg_d;
      an_q    <= an_d;
    end
  end

  assign tens = count_q.tens;
  assign ones = count_q.ones;
  assign wrap = wrap_q;
  assign seg  = seg_q;
  assign an   = an_q;
  assign dp   = 1'b1;

endmodule

// File: tb/tb_mod100_down_display.sv
// Scoreboard bench for mod100_down_display: stimulus pushes expected counts,
// a monitor pops them whenever the displayed count changes.
module tb_mod100_down_display;

  logic       clk = 1'b0;
  logic       rst, sclk_in, en, load;
  logic [3:0] tens, ones;
  logic       wrap;
  logic [6:0] seg;
  logic       dp;
  logic [7:0] an;

  always #5 clk = ~clk;

  mod100_down_display #(.SCAN_DIV(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .sclk_in (sclk_in),
    .en      (en),
    .load    (load),
    .tens    (tens),
    .ones    (ones),
    .wrap    (wrap),
    .seg     (seg),
    .dp      (dp),
    .an      (an)
  );

  typedef struct {
    int t;
    int o;
    int w;
    int cyc;
  } exp_t;

  exp_t sbq[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  int   wrap_cnt = 0;
  int   m_t      = 9;
  int   m_o      = 9;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: any change of the displayed count must match the next expectation
  initial begin
    logic [7:0] prev;
    exp_t       e;
    prev = 8'h99;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev = {tens, ones};
      end else begin
        if (wrap === 1'b1) wrap_cnt++;
        if ({tens, ones} !== prev) begin
          if (sbq.size() == 0) begin
            chk("unexpected_count_change", {24'h0, tens, ones}, {24'h0, prev});
          end else begin
            e = sbq.pop_front();
            chk("count_tens", 32'(tens), e.t);
            chk("count_ones", 32'(ones), e.o);
            chk("wrap_on_update", 32'(wrap), e.w);
            chk("update_cycle", cyc, e.cyc);
          end
          prev = {tens, ones};
        end
      end
    end
  end

  task automatic model_dec(output int w);
    w = 0;
    if (m_t == 0 && m_o == 0) begin
      m_t = 9; m_o = 9; w = 1;
    end else if (m_o == 0) begin
      m_o = 9; m_t = m_t - 1;
    end else begin
      m_o = m_o - 1;
    end
  endtask

  task automatic sclk_pulse(input int hi);
    int w;
    @(negedge clk);
    sclk_in = 1'b1;
    if (en) begin
      model_dec(w);
      sbq.push_back('{m_t, m_o, w, cyc + 3});
    end
    repeat (hi) @(negedge clk);
    sclk_in = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic pulses(input int n);
    repeat (n) sclk_pulse(4);
  endtask

  task automatic do_load();
    @(negedge clk);
    load = 1'b1;
    m_t = 9; m_o = 9;
    sbq.push_back('{9, 9, 0, cyc + 1});
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sbq.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("scoreboard_drained", sbq.size(), 0);
    sbq.delete();
  endtask

  task automatic chk_count(input string name, input int t, input int o);
    chk({name, "_tens"}, 32'(tens), t);
    chk({name, "_ones"}, 32'(ones), o);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int ones_slots;
    int c0;
    rst = 1'b1; sclk_in = 1'b0; en = 1'b1; load = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_an", 32'(an), 32'hFF);
    chk("rst_seg", 32'(seg), 32'h7F);
    chk("rst_dp", 32'(dp), 1);
    chk("rst_wrap", 32'(wrap), 0);
    chk_count("rst", 9, 9);
    rst = 1'b0;
    @(negedge clk);
    chk("first_scan_an", 32'(an), 32'hFE);
    chk("first_scan_seg", 32'(seg), 32'b0010000);

    // Latency: one rise held high for 1000 clk -> exactly one decrement
    sclk_pulse(1000);
    drain();
    chk_count("latency", 9, 8);

    // Wrap: 100 rises from 99 return to 99 with one wrap pulse
    do_load();
    drain();
    wrap_cnt = 0;
    pulses(100);
    drain();
    chk("wrap_pulse_count", wrap_cnt, 1);
    chk_count("after_wrap", 9, 9);

    // Load versus coincident tick at 45
    pulses(54);
    drain();
    chk_count("at45", 4, 5);
    @(negedge clk);
    sclk_in = 1'b1;
    c0 = cyc;
    m_t = 9; m_o = 9;
    sbq.push_back('{9, 9, 0, c0 + 3});
    repeat (2) @(negedge clk);
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    repeat (2) @(negedge clk);
    sclk_in = 1'b0;
    repeat (6) @(negedge clk);
    drain();
    chk_count("load_priority", 9, 9);
    chk("load_no_wrap", wrap_cnt, 1);

    // en low: ticks ignored
    en = 1'b0;
    pulses(5);
    en = 1'b1;
    chk_count("en_low", 9, 9);

    // Scan at 37: tens slot then ones slot, 4 clk each
    pulses(62);
    drain();
    chk_count("at37", 3, 7);
    n = 0;
    while (an !== 8'hFD && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("scan_sync_tens", 32'(an), 32'hFD);
    for (int i = 0; i < 8; i++) begin
      if (i < 4) begin
        chk("scan_tens_an", 32'(an), 32'hFD);
        chk("scan_tens_seg", 32'(seg), 32'b0110000);
      end else begin
        chk("scan_ones_an", 32'(an), 32'hFE);
        chk("scan_ones_seg", 32'(seg), 32'b1111000);
      end
      @(negedge clk);
    end

    // Leading-zero handling at 07
    pulses(30);
    drain();
    chk_count("at07", 0, 7);
    ones_slots = 0;
    for (int i = 0; i < 8; i++) begin
      if (an === 8'hFE) begin
        ones_slots++;
        chk("blank_ones_seg", 32'(seg), 32'b1111000);
      end else begin
`ifdef MOD100_DISPLAY_BLANK_EN
        chk("blank_tens_an", 32'(an), 32'hFF);
`else
        chk("blank_tens_an", 32'(an), 32'hFD);
        chk("blank_tens_seg", 32'(seg), 32'b1000000);
`endif
      end
      @(negedge clk);
    end
    chk("blank_ones_slots", ones_slots, 4);

    // Reset while sclk_in is high: the rise is seen again after release
    @(negedge clk);
    sclk_in = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    m_t = 9; m_o = 9;
    repeat (2) @(negedge clk);
    chk("midrst_an", 32'(an), 32'hFF);
    chk_count("midrst", 9, 9);
    rst = 1'b0;
    m_t = 9; m_o = 8;
    sbq.push_back('{9, 8, 0, cyc + 3});
    repeat (4) @(negedge clk);
    sclk_in = 1'b0;
    repeat (4) @(negedge clk);
    drain();
    chk_count("after_rst_tick", 9, 8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
